mst_bus_arbiter: RTL
====================

# mst_bus_arbiter

Round-robin arbiter for the MiniRISC master data bus. It shares the single data-memory/peripheral bus between up to `NUM_MASTERS` bus masters, such as the CPU, a DMA engine and the debug module. Each master owns a `bus_req`/`bus_grant` pair, and the block merges the masters' outputs onto the slave bus. It sits between the masters' `m_*` ports and the slave-side address decoder. An optional hold limit bounds how long one master can own the bus.

## Interface
- `NUM_MASTERS`, default 4: number of masters, legal range 2–8; index 0 is the CPU.
- `MAX_HOLD`, default 0: maximum consecutive granted cycles before forced rotation; 0 disables preemption.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  reset; one clock; reset is asynchronous and active-low.
- `mst_req`  input  NUM_MASTERS  per-master bus request, bit i is master i.
- `mst_grant`  output  NUM_MASTERS  per-master grant, one-hot or zero.
- `mst_addr`  input  8*NUM_MASTERS  flattened address buses; master i occupies [8i+7:8i].
- `mst_wr`  input  NUM_MASTERS  write strobes.
- `mst_rd`  input  NUM_MASTERS  read strobes.
- `mst_wdata`  input  8*NUM_MASTERS  flattened write data.
- `slv_addr`  output  8  merged address to slaves.
- `slv_wr`  output  1  merged write strobe.
- `slv_rd`  output  1  merged read strobe.
- `slv_wdata`  output  8  merged write data.
- `bus_busy`  output  1  some master holds the grant.
- `owner`  output  3  index of the current owner; 0 when idle.

## Operation
- State machine with two states.
  - IDLE: no owner. Stays in IDLE while `mst_req == 0`. Otherwise goes to OWNED, with the owner chosen by the picker.
  - OWNED: the owner keeps the bus while its `mst_req` bit is high and the hold limit has not expired.
- When the owner releases (`mst_req[owner]` = 0) or is preempted, the next owner is picked in the same cycle.
  - If there are other requesters, the state stays OWNED with the new owner.
  - If there are none, the state goes to IDLE.
- Round-robin picker: the search starts at `last_owner + 1` modulo `NUM_MASTERS` and takes the first set request bit.
  - `last_owner` updates on every grant.
  - Reset value of `last_owner` is `NUM_MASTERS - 1`, so master 0 wins the first contention.
- Hold counter:
  - Clears on every change of owner.
  - Increments each OWNED cycle and saturates at `MAX_HOLD`.
  - When it reaches `MAX_HOLD` (only if `MAX_HOLD` > 0) and another master is requesting, the owner is preempted.
  - If no other master is requesting, the owner keeps the bus and the counter stays saturated.
- `mst_grant[i]` = `grant_q[i] & mst_req[i]`. A grant drops combinationally in the same cycle its request drops.
- Slave bus merge is a bitwise OR across masters of each signal gated by that master's `mst_grant` bit. Ungranted inputs are ignored even if nonzero, so an idle bus drives all zeros.
- Read data is not handled here; slaves broadcast to all masters.

## Timing
- Reset values: `grant_q` = 0, state = IDLE, `mst_grant` = 0, `slv_*` = 0, `bus_busy` = 0, `owner` = 0, hold counter = 0.
- Request-to-grant latency on an idle bus is 1 cycle: request sampled at edge n, grant visible after edge n.
- Handover takes 1 cycle. Old owner drops request in cycle n; its grant is low in cycle n; the new owner's grant is high after edge n. No cycle exists with two grants.
- Preemption: an owner granted for `MAX_HOLD` consecutive cycles loses its grant at the following edge if any other request is pending.
  - A preempted owner that still requests re-enters round-robin order.
- Simultaneous release and new request: the picker sees the current-cycle `mst_req`, so a master requesting in the release cycle is eligible.
- Asserting `rst` mid-transfer clears all grants immediately (asynchronous). The slave bus goes to zeros without waiting for a clock.
- A single requester holds the bus indefinitely when `MAX_HOLD` = 0. A single requester also keeps the bus when the hold counter saturates, because nothing else is requesting.

## Structure
- Shared package `minirisc_bus_pkg`:
  - bus widths: `ADDR_W` = 8, `DATA_W` = 8;
  - `MAX_MASTERS` = 8;
  - owner index width constant of 3 bits;
  - the state encoding (IDLE/OWNED).
- Sub-module `rr_picker`: combinational, takes request vector and `last_owner`, returns the one-hot pick plus a valid flag. It is reused by the interrupt arbiter.
- The top level holds the FSM, `grant_q`, `last_owner`, the hold counter and the OR-merge.

## Test plan
- Single request: after reset, `mst_req` = 4'b0001 → `mst_grant` = 4'b0001 one cycle later. `slv_addr` follows `mst_addr[7:0]` = 8'h80; `bus_busy` = 1.
- Contention: `mst_req` = 4'b1111 held, and each owner drops its request for one cycle after 2 granted cycles → grant order 0,1,2,3,0. Never two bits set.
- Release/handover: master 2 owns, master 1 requests. Master 2 drops its request in cycle n → `mst_grant[2]` = 0 in cycle n and `mst_grant[1]` = 1 in cycle n+1.
- Preemption with `MAX_HOLD` = 3: masters 0 and 3 both request continuously → grant alternates 3 cycles to 0, then 3 cycles to 3. With only master 0 requesting, its grant is never removed.
- Isolation: ungranted master 1 drives `mst_wr` = 1 and address 8'hFF while master 0 owns with 8'h10 → `slv_wr` = `mst_wr[0]` and `slv_addr` = 8'h10.
- Reset mid-operation: assert `rst` low while master 2 writes → `mst_grant` = 0 and `slv_*` = 0 before the next edge. After release, the first contention between masters 0 and 2 goes to master 0.

Source files
------------

// File: rtl/minirisc_bus_pkg.sv
// MiniRISC data-bus shared widths, owner index type and arbiter states.
// Shared by the bus arbiter and the interrupt arbiter.
package minirisc_bus_pkg;

  localparam int ADDR_W      = 8;
  localparam int DATA_W      = 8;
  localparam int MAX_MASTERS = 8;
  localparam int OWNER_W     = 3;

  typedef logic [OWNER_W-1:0] owner_t;

  typedef enum logic {
    IDLE,
    OWNED
  } arb_state_e;

  function automatic owner_t oh_to_idx(
    input logic [MAX_MASTERS-1:0] oh
  );
    owner_t idx;
    idx = '0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      if (oh[i]) idx = owner_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mst_bus_arbiter_if.sv
// Master data bus bundle: per-master request/grant and strobes,
// plus the merged slave-side bus.
interface mst_bus_arbiter_if
  import minirisc_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 4
);

  logic [NUM_MASTERS-1:0]        mst_req;
  logic [NUM_MASTERS-1:0]        mst_grant;
  logic [ADDR_W*NUM_MASTERS-1:0] mst_addr;
  logic [NUM_MASTERS-1:0]        mst_wr;
  logic [NUM_MASTERS-1:0]        mst_rd;
  logic [DATA_W*NUM_MASTERS-1:0] mst_wdata;

  logic [ADDR_W-1:0] slv_addr;
  logic              slv_wr;
  logic              slv_rd;
  logic [DATA_W-1:0] slv_wdata;

  logic   bus_busy;
  owner_t owner;

  modport arbiter (
    input  mst_req,
    input  mst_addr,
    input  mst_wr,
    input  mst_rd,
    input  mst_wdata,
    output mst_grant,
    output slv_addr,
    output slv_wr,
    output slv_rd,
    output slv_wdata,
    output bus_busy,
    output owner
  );

  modport master (
    output mst_req,
    output mst_addr,
    output mst_wr,
    output mst_rd,
    output mst_wdata,
    input  mst_grant,
    input  bus_busy,
    input  owner
  );

  modport slave (
    input slv_addr,
    input slv_wr,
    input slv_rd,
    input slv_wdata,
    input bus_busy
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set request after last.
// Returns a one-hot pick and a valid flag.
module rr_picker
  import minirisc_bus_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  owner_t       last,
  output logic [N-1:0] pick,
  output logic         valid
);

  // Two passes: indices above last first, then wrap to 0..last.
  always_comb begin
    pick  = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!valid && req[i] && i > int'(last)) begin
        pick[i] = 1'b1;
        valid   = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!valid && req[i] && i <= int'(last)) begin
        pick[i] = 1'b1;
        valid   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mst_bus_arbiter.sv
// Round-robin arbiter for the MiniRISC master data bus with an
// optional hold limit and a grant-gated OR merge onto the slave bus.
module mst_bus_arbiter
  import minirisc_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int MAX_HOLD    = 0
) (
  input  logic               clk,
  input  logic               rst,
  mst_bus_arbiter_if.arbiter bus
);

  localparam int N      = NUM_MASTERS;
  localparam int HOLD_W =
    (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  arb_state_e        state_q;
  logic [N-1:0]      grant_q;
  owner_t            owner_q;
  owner_t            last_q;
  logic [HOLD_W-1:0] hold_q;

  logic [N-1:0] pick;
  logic [N-1:0] grant;
  logic         pick_vld;
  owner_t       pick_idx;
  logic         others;
  logic         expire;
  logic         keep;

  rr_picker #(
    .N (N)
  ) u_pick (
    .req   (bus.mst_req),
    .last  (last_q),
    .pick  (pick),
    .valid (pick_vld)
  );

  assign pick_idx = oh_to_idx(MAX_MASTERS'(pick));
  assign others   = |(bus.mst_req & ~grant_q);

  // hold_q counts completed cycles, so +1 includes this one.
  assign expire = (MAX_HOLD > 0)
               && (int'(hold_q) + 1 >= MAX_HOLD)
               && others;
  assign keep   = (|(bus.mst_req & grant_q)) && !expire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= owner_t'(N - 1);
      hold_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_vld) begin
            state_q <= OWNED;
            grant_q <= pick;
            owner_q <= pick_idx;
            last_q  <= pick_idx;
            hold_q  <= '0;
          end
        end
        OWNED: begin
          if (keep) begin
            if (int'(hold_q) < MAX_HOLD)
              hold_q <= hold_q + 1'b1;
          end else if (pick_vld) begin
            grant_q <= pick;
            owner_q <= pick_idx;
            last_q  <= pick_idx;
            hold_q  <= '0;
          end else begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            hold_q  <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant = grant_q & bus.mst_req;

  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_wr;
  logic              m_rd;

  always_comb begin
    m_addr  = '0;
    m_wdata = '0;
    m_wr    = 1'b0;
    m_rd    = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_addr  |= bus.mst_addr[ADDR_W*i +: ADDR_W]
               & {ADDR_W{grant[i]}};
      m_wdata |= bus.mst_wdata[DATA_W*i +: DATA_W]
               & {DATA_W{grant[i]}};
      m_wr    |= bus.mst_wr[i] & grant[i];
      m_rd    |= bus.mst_rd[i] & grant[i];
    end
  end

  assign bus.mst_grant = grant;
  assign bus.slv_addr  = m_addr;
  assign bus.slv_wdata = m_wdata;
  assign bus.slv_wr    = m_wr;
  assign bus.slv_rd    = m_rd;
  assign bus.bus_busy  = (state_q == OWNED);
  assign bus.owner     = owner_q;

endmodule
